// File: rtl/ctrl_output_conditioner.sv
// Output conditioner for DAC channel 2: offset add, clamp, slew limit and
// offset-binary conversion, with a ramp-to-zero mode when disabled.
module ctrl_output_conditioner #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] limit_min,
  input  logic [DATA_WIDTH-1:0] limit_max,
  input  logic [STEP_WIDTH-1:0] max_step,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  out_valid,
  output logic                  sat_hi,
  output logic                  sat_lo,
  output logic                  slew_active,
  output logic                  cfg_err
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;
  // diff needs DATA_WIDTH+2 bits; widen further if max_step is wider
  localparam int unsigned CW = ((DATA_WIDTH + 2) > (STEP_WIDTH + 1)) ?
                               (DATA_WIDTH + 2) : (STEP_WIDTH + 1);

  typedef enum logic {
    ST_TRACK     = 1'b0,
    ST_RAMP_DOWN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_s1_ramp;

  logic signed [SUM_W-1:0]      w_sum;
  logic                         r_s1_valid;
  logic                         r_s1_ramp;
  logic signed [SUM_W-1:0]      r_s1_sum;
  logic signed [DATA_WIDTH-1:0] r_s1_min;
  logic signed [DATA_WIDTH-1:0] r_s1_max;
  logic [STEP_WIDTH-1:0]        r_s1_step;

  logic signed [DATA_WIDTH-1:0] w_s2_target;
  logic                         w_s2_hi;
  logic                         w_s2_lo;
  logic                         w_s2_cfg;
  logic                         r_s2_valid;
  logic signed [DATA_WIDTH-1:0] r_s2_target;
  logic                         r_s2_hi;
  logic                         r_s2_lo;
  logic                         r_s2_cfg;
  logic [STEP_WIDTH-1:0]        r_s2_step;

  logic signed [DATA_WIDTH-1:0] r_cur;
  logic signed [CW-1:0]         w_diff;
  logic [CW-1:0]                w_abs;
  logic [CW-1:0]                w_step_ext;
  logic                         w_limit;
  logic [DATA_WIDTH-1:0]        w_cur_step;
  logic [DATA_WIDTH-1:0]        w_cur_nxt;

  // Mode FSM advances only on accepted samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_TRACK;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s1_ramp   = 1'b0;
    if (in_valid) begin
      case (r_state)
        ST_TRACK:     if (!enable) w_state_nxt = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (enable)  w_state_nxt = ST_TRACK;
        default:      w_state_nxt = ST_TRACK;
      endcase
    end
    w_s1_ramp = (w_state_nxt == ST_RAMP_DOWN);
  end

  assign w_sum = $signed({in_data[DATA_WIDTH-1], in_data}) +
                 $signed({offset[DATA_WIDTH-1], offset});

  // S1: offset add and configuration capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_ramp  <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_min   <= '0;
      r_s1_max   <= '0;
      r_s1_step  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_ramp <= w_s1_ramp;
        r_s1_sum  <= w_s1_ramp ? '0 : w_sum;
        r_s1_min  <= $signed(limit_min);
        r_s1_max  <= $signed(limit_max);
        r_s1_step <= max_step;
      end
    end
  end

  // S2: clamp; a ramping sample targets zero and bypasses the window
  always_comb begin
    w_s2_target = r_s1_sum[DATA_WIDTH-1:0];
    w_s2_hi     = 1'b0;
    w_s2_lo     = 1'b0;
    w_s2_cfg    = 1'b0;
    if (r_s1_ramp) begin
      w_s2_target = '0;
    end else if (r_s1_min > r_s1_max) begin
      w_s2_target = r_s1_min;
      w_s2_cfg    = 1'b1;
    end else if (r_s1_sum > SUM_W'(r_s1_max)) begin
      w_s2_target = r_s1_max;
      w_s2_hi     = 1'b1;
    end else if (r_s1_sum < SUM_W'(r_s1_min)) begin
      w_s2_target = r_s1_min;
      w_s2_lo     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_target <= '0;
      r_s2_hi     <= 1'b0;
      r_s2_lo     <= 1'b0;
      r_s2_cfg    <= 1'b0;
      r_s2_step   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_target <= w_s2_target;
        r_s2_hi     <= w_s2_hi;
        r_s2_lo     <= w_s2_lo;
        r_s2_cfg    <= w_s2_cfg;
        r_s2_step   <= r_s1_step;
      end
    end
  end

  // S3: slew limit toward target
  assign w_diff     = CW'(r_s2_target) - CW'(r_cur);
  assign w_abs      = w_diff[CW-1] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_step_ext = CW'(r_s2_step);
  assign w_limit    = (r_s2_step != '0) && (w_abs > w_step_ext);
  assign w_cur_step = w_diff[CW-1] ? ($unsigned(r_cur) - DATA_WIDTH'(r_s2_step))
                                   : ($unsigned(r_cur) + DATA_WIDTH'(r_s2_step));
  assign w_cur_nxt  = w_limit ? w_cur_step : $unsigned(r_s2_target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur       <= '0;
      out_valid   <= 1'b0;
      sat_hi      <= 1'b0;
      sat_lo      <= 1'b0;
      slew_active <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_cur       <= $signed(w_cur_nxt);
        sat_hi      <= r_s2_hi;
        sat_lo      <= r_s2_lo;
        slew_active <= w_limit;
        cfg_err     <= r_s2_cfg;
      end
    end
  end

  assign dac_data = {~r_cur[DATA_WIDTH-1], r_cur[DATA_WIDTH-2:0]};

endmodule

// File: tb/tb_ctrl_output_conditioner.sv
// Bench for ctrl_output_conditioner: directed scenarios plus random traffic
// checked against an integer-arithmetic reference model.
module tb_ctrl_output_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] offset;
  logic [15:0] limit_min;
  logic [15:0] limit_max;
  logic [15:0] max_step;
  logic        enable;
  logic [15:0] dac_data;
  logic        out_valid;
  logic        sat_hi;
  logic        sat_lo;
  logic        slew_active;
  logic        cfg_err;

  typedef struct {
    logic        v;
    logic [15:0] dac;
    logic        hi;
    logic        lo;
    logic        sl;
    logic        cfg;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   mcur;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic signed [15:0] ra, rb;

  always #5 clk = ~clk;

  ctrl_output_conditioner #(.DATA_WIDTH(16), .STEP_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .offset(offset), .limit_min(limit_min), .limit_max(limit_max),
    .max_step(max_step), .enable(enable), .dac_data(dac_data),
    .out_valid(out_valid), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .slew_active(slew_active), .cfg_err(cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one accepted sample, applied to the model's output value
  task automatic model(input logic [15:0] d, output exp_t e);
    int sum, mn, mx, tgt, diff, st;
    e = '{v: 1'b1, dac: 16'h0, hi: 1'b0, lo: 1'b0, sl: 1'b0, cfg: 1'b0};
    mn = int'($signed(limit_min));
    mx = int'($signed(limit_max));
    st = int'(max_step);
    if (!enable) tgt = 0;
    else begin
      sum = int'($signed(d)) + int'($signed(offset));
      if (mn > mx)       begin tgt = mn; e.cfg = 1'b1; end
      else if (sum > mx) begin tgt = mx; e.hi  = 1'b1; end
      else if (sum < mn) begin tgt = mn; e.lo  = 1'b1; end
      else tgt = sum;
    end
    diff = tgt - mcur;
    if (st != 0 && (diff > st || -diff > st)) begin
      mcur = (diff > 0) ? mcur + st : mcur - st;
      e.sl = 1'b1;
    end else begin
      mcur = tgt;
    end
    e.dac = 16'(mcur + 32768);
  endtask

  task automatic flush_model();
    exp_t b;
    b = '{v: 1'b0, dac: 16'h0, hi: 1'b0, lo: 1'b0, sl: 1'b0, cfg: 1'b0};
    q.delete();
    q.push_back(b);
    q.push_back(b);
    mcur = 0;
    held = '{v: 1'b0, dac: 16'h8000, hi: 1'b0, lo: 1'b0, sl: 1'b0, cfg: 1'b0};
  endtask

  // One clock: drive, predict, then compare the output that emerges this cycle
  task automatic step(input logic v, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    if (v) model(d, e);
    else   e = '{v: 1'b0, dac: 16'h0, hi: 1'b0, lo: 1'b0, sl: 1'b0, cfg: 1'b0};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.v) held = e;
    chk("out_valid",   32'(out_valid),   32'(e.v));
    chk("dac_data",    32'(dac_data),    32'(held.dac));
    chk("sat_hi",      32'(sat_hi),      32'(held.hi));
    chk("sat_lo",      32'(sat_lo),      32'(held.lo));
    chk("slew_active", 32'(slew_active), 32'(held.sl));
    chk("cfg_err",     32'(cfg_err),     32'(held.cfg));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; offset = '0;
    limit_min = 16'h8001; limit_max = 16'h7FFF; max_step = '0; enable = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac",   32'(dac_data),  32'h8000);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_flags", 32'({sat_hi, sat_lo, slew_active, cfg_err}), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // pass-through
    step(1'b1, 16'h1234); step(1'b0, 16'h0); step(1'b0, 16'h0);
    chk("pt_dac", 32'(dac_data), 32'h9234);

    // offset + upper clamp, then lower clamp
    offset = 16'h4000; limit_max = 16'h6000;
    step(1'b1, 16'h5000); step(1'b0, 16'h0); step(1'b0, 16'h0);
    chk("clamp_hi", 32'({dac_data, sat_hi}), 32'({16'hE000, 1'b1}));
    offset = 16'h0000; limit_min = 16'hC000;
    step(1'b1, 16'h8000); step(1'b0, 16'h0); step(1'b0, 16'h0);
    chk("clamp_lo", 32'({dac_data, sat_lo}), 32'({16'h4000, 1'b1}));

    // slew limit from zero
    limit_min = 16'h8001; limit_max = 16'h7FFF;
    step(1'b1, 16'h0000);
    max_step = 16'h0100;
    repeat (4) step(1'b1, 16'h0350);
    step(1'b0, 16'h0); step(1'b0, 16'h0);
    chk("slew_end", 32'({dac_data, slew_active}), 32'({16'h8350, 1'b0}));

    // ramp-down and recovery without a jump
    max_step = 16'h0000;
    step(1'b1, 16'h0300);
    max_step = 16'h0100; enable = 1'b0;
    repeat (5) step(1'b1, 16'h7000);
    enable = 1'b1;
    step(1'b1, 16'h0300); step(1'b0, 16'h0); step(1'b0, 16'h0);
    chk("ramp_resume", 32'(dac_data), 32'h8100);

    // back-to-back strobes
    max_step = 16'h0000;
    for (int i = 0; i < 10; i++) step(1'b1, 16'($urandom));

    // inverted limits
    limit_min = 16'h0100; limit_max = 16'h0000;
    step(1'b1, 16'h1234); step(1'b0, 16'h0); step(1'b0, 16'h0);
    chk("cfg_err", 32'({dac_data, cfg_err}), 32'({16'h8100, 1'b1}));

    // reset one cycle after a strobe
    limit_min = 16'h8001; limit_max = 16'h7FFF;
    step(1'b1, 16'h0400);
    #2;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_dac",   32'(dac_data),  32'h8000);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    flush_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step(1'b0, 16'h0);

    // randomized traffic with live reconfiguration
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        offset = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
        ra = 16'($urandom);
        rb = 16'($urandom);
        if ((ra > rb) != ($urandom_range(0, 7) == 0)) begin
          limit_min = rb; limit_max = ra;
        end else begin
          limit_min = ra; limit_max = rb;
        end
        case ($urandom_range(0, 2))
          0:       max_step = 16'h0000;
          1:       max_step = 16'($urandom_range(1, 16'h0800));
          default: max_step = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      step($urandom_range(0, 3) != 0, 16'($urandom));
    end
    repeat (3) step(1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
